// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding,
// digit-count limit and the hex-to-segment code table (bit order g..a).
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_SHOW = 2'd2
  } scan_state_t;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern (g..a).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_CODES[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-select 7-segment display:
// digit register file, slot prescaler with blanking dead-time, registered drive.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DIGITS  = 8,
  parameter int DEAD    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [7:0] blank_mask,
  output logic [7:0] seg_led,
  output logic [7:0] seg_sel,
  output logic [2:0] scan_idx
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;

  scan_state_t   state_reg;
  logic [PW-1:0] presc_reg;
  logic [DW-1:0] dead_cnt_reg;
  logic [2:0]    idx_reg;
  logic [2:0]    idx_next;

  // Padded to the full 8 entries so the 3-bit index never reads out of range;
  // entries at or above DIGITS are never written and stay zero.
  logic [4:0]    rf_reg [MAX_DIGITS];
  logic [4:0]    rd_value;
  logic [6:0]    rd_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_DIGITS; i++) rf_reg[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < DIGITS)) begin
      rf_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_value = rf_reg[idx_reg];
  assign idx_next = (int'(idx_reg) == DIGITS - 1) ? 3'd0 : idx_reg + 3'd1;

  seg_hex_decode u_decode (
    .hex (rd_value[3:0]),
    .seg (rd_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      presc_reg    <= '0;
      dead_cnt_reg <= '0;
      idx_reg      <= '0;
    end else if (!en) begin
      state_reg    <= ST_IDLE;
      presc_reg    <= '0;
      dead_cnt_reg <= '0;
      idx_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg    <= (DEAD == 0) ? ST_SHOW : ST_DEAD;
          presc_reg    <= '0;
          dead_cnt_reg <= '0;
          idx_reg      <= '0;
        end
        ST_DEAD, ST_SHOW: begin
          if (int'(presc_reg) == CLK_DIV - 1) begin
            presc_reg    <= '0;
            dead_cnt_reg <= '0;
            idx_reg      <= idx_next;
            state_reg    <= (DEAD == 0) ? ST_SHOW : ST_DEAD;
          end else begin
            presc_reg <= presc_reg + 1'b1;
            // Dead window always closes before the slot end since DEAD < CLK_DIV.
            if (state_reg == ST_DEAD) begin
              dead_cnt_reg <= dead_cnt_reg + 1'b1;
              if (int'(dead_cnt_reg) == DEAD - 1) state_reg <= ST_SHOW;
            end
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          presc_reg    <= '0;
          dead_cnt_reg <= '0;
          idx_reg      <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_led  <= '0;
      seg_sel  <= '0;
      scan_idx <= '0;
    end else begin
      scan_idx <= idx_reg;
      if (state_reg == ST_SHOW && !blank_mask[idx_reg]) begin
        seg_sel <= 8'd1 << idx_reg;
        seg_led <= {rd_value[4], rd_seg};
      end else begin
        seg_sel <= '0;
        seg_led <= '0;
      end
    end
  end

endmodule
